debounce_multi: RTL

- Parametrised successor to the single-channel button debouncer.
- Debounces CHANNELS independent noisy inputs (buttons and switches) with a compile-time debounce interval and a selectable reset level.
- Each channel has its own counter and 4-state FSM, plus registered one-cycle rise/fall strobes so downstream logic (e.g. transmitter send triggers) needs no separate edge detector.
- Sits between board pins and the control FSMs.

---
 rtl/debounce_multi_if.sv | 25 ++
 rtl/debounce_multi.sv | 130 +++++++++++++
 2 files changed

// File: rtl/debounce_multi_if.sv
// debounce_multi_if: bundles the raw pin inputs and the cleaned outputs of the
// multi-channel debouncer. The master side drives the noisy pins and observes
// the debounced levels and strobes. The slave side is the debouncer itself.
interface debounce_multi_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] noisy;
    logic [CHANNELS-1:0] debounced;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    modport master (
        output noisy,
        input  debounced,
        input  rise,
        input  fall
    );

    modport slave (
        input  noisy,
        output debounced,
        output rise,
        output fall
    );
endinterface

// File: rtl/debounce_multi.sv
// debounce_multi: CHANNELS independent debouncers, each with its own counter
// and 4-state FSM, plus registered one-cycle rise/fall strobes.
// A new level must be seen on DEBOUNCE_CYCLES+1 consecutive samples before
// the debounced output follows it; shorter bursts are discarded silently.
// Optional macro DEBOUNCE_SYNC_EN: inserts a two-flop synchroniser per channel
// in front of the FSM (adds 2 cycles of latency). Without it the FSM samples
// noisy directly, which suits inputs already synchronous to clk.
module debounce_multi #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int INIT_LEVEL      = 0
) (
    input logic             clk,
    input logic             reset,
    debounce_multi_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
    localparam logic INIT_BIT = (INIT_LEVEL != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        WAIT_HI = 2'd1,
        ST_HI   = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam state_t RESET_STATE = INIT_BIT ? ST_HI : ST_LO;

    logic [CHANNELS-1:0] deb_q;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] fall_q;

    assign bus.debounced = deb_q;
    assign bus.rise      = rise_q;
    assign bus.fall      = fall_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic                 s;
        state_t               state;
        logic [CNT_WIDTH-1:0] cnt;
        logic                 deb_r;
        logic                 rise_r;
        logic                 fall_r;

`ifdef DEBOUNCE_SYNC_EN
        logic sync1;
        logic sync2;

        // Two-flop synchroniser so the FSM never sees a metastable pin value.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync1 <= INIT_BIT;
                sync2 <= INIT_BIT;
            end else begin
                sync1 <= bus.noisy[i];
                sync2 <= sync1;
            end
        end

        assign s = sync2;
`else
        assign s = bus.noisy[i];
`endif

        // Per-channel FSM: the debounced level and strobes only change when a
        // WAIT state completes its full interval, so they are registered here.
        always_ff @(posedge clk) begin
            if (reset) begin
                state  <= RESET_STATE;
                cnt    <= '0;
                deb_r  <= INIT_BIT;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end else begin
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                case (state)
                    ST_LO: begin
                        cnt <= '0;
                        if (s) begin
                            state <= WAIT_HI;
                        end
                    end
                    WAIT_HI: begin
                        if (!s) begin
                            state <= ST_LO;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state  <= ST_HI;
                            cnt    <= '0;
                            deb_r  <= 1'b1;
                            rise_r <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_WIDTH'(1);
                        end
                    end
                    ST_HI: begin
                        cnt <= '0;
                        if (!s) begin
                            state <= WAIT_LO;
                        end
                    end
                    WAIT_LO: begin
                        if (s) begin
                            state <= ST_HI;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state  <= ST_LO;
                            cnt    <= '0;
                            deb_r  <= 1'b0;
                            fall_r <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state <= ST_LO;
                        cnt   <= '0;
                        deb_r <= 1'b0;
                    end
                endcase
            end
        end

        assign deb_q[i]  = deb_r;
        assign rise_q[i] = rise_r;
        assign fall_q[i] = fall_r;
    end
endmodule
